// File: rtl/iops_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : iops_sweep_ctrl_if
// Brief    : Control, generator-debug, AXI snoop and result signals of the
//            IOPS sweep controller bundled as one interface.
// Revision : 1.0 - initial release
// ============================================================================
interface iops_sweep_ctrl_if #(
    parameter int LEN_SIZE = 4
);
    logic                start;
    logic [LEN_SIZE-1:0] cfg_len_max;
    logic                busy;
    logic                done;
    logic [2:0]          debug_arsize;
    logic [LEN_SIZE-1:0] debug_arlen;
    logic                debug_pause;
    logic                axi_arvalid;
    logic                axi_arready;
    logic                axi_rvalid;
    logic                axi_rready;
    logic                axi_rlast;
    logic                result_valid;
    logic                result_ready;
    logic [2:0]          result_arsize;
    logic [LEN_SIZE-1:0] result_arlen;
    logic [31:0]         result_count;
    logic                result_err;

    modport master (
        input  start, cfg_len_max,
        input  axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast,
        input  result_ready,
        output busy, done, debug_arsize, debug_arlen, debug_pause,
        output result_valid, result_arsize, result_arlen, result_count, result_err
    );

    modport slave (
        output start, cfg_len_max,
        output axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast,
        output result_ready,
        input  busy, done, debug_arsize, debug_arlen, debug_pause,
        input  result_valid, result_arsize, result_arlen, result_count, result_err
    );
endinterface
`default_nettype wire

// File: rtl/iops_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iops_sweep_ctrl
// Brief    : Sweeps arsize/arlen of the random-read generator, measures
//            completed bursts per point and reports one result per point.
// Revision : 1.0 - initial release
// ============================================================================
module iops_sweep_ctrl #(
    parameter int LEN_SIZE      = 4,
    parameter int SIZE_MIN      = 0,
    parameter int SIZE_MAX      = 3,
    parameter int WINDOW_LEN    = 1024,
    parameter int OUTST_W       = 8,
    parameter int DRAIN_TIMEOUT = 65535
) (
    input  logic              clock,
    input  logic              reset,
    iops_sweep_ctrl_if.master bus
);
    localparam int c_win_w = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam int c_drn_w = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW_LEN - 1);
    localparam logic [c_drn_w-1:0] c_drn_last = c_drn_w'(DRAIN_TIMEOUT - 1);
    localparam logic [2:0]         c_size_min = 3'(SIZE_MIN);
    localparam logic [2:0]         c_size_max = 3'(SIZE_MAX);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_setup  = 3'd1;
    localparam logic [2:0] c_st_run    = 3'd2;
    localparam logic [2:0] c_st_drain  = 3'd3;
    localparam logic [2:0] c_st_report = 3'd4;
    localparam logic [2:0] c_st_done   = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [LEN_SIZE-1:0] r_len_max;
    logic [2:0]          r_arsize;
    logic [LEN_SIZE-1:0] r_arlen;
    logic [c_win_w-1:0]  r_win;
    logic [c_drn_w-1:0]  r_drain;
    logic [OUTST_W-1:0]  r_outst;
    logic                r_err;
    logic [31:0]         r_count;

    logic                r_busy;
    logic                r_done;
    logic                r_pause;
    logic [2:0]          r_dbg_arsize;
    logic [LEN_SIZE-1:0] r_dbg_arlen;
    logic                r_res_valid;
    logic [2:0]          r_res_arsize;
    logic [LEN_SIZE-1:0] r_res_arlen;
    logic [31:0]         r_res_count;
    logic                r_res_err;

    logic w_ar_hs;
    logic w_r_done;
    logic w_uflow;
    logic w_oflow;
    logic w_err_evt;
    logic w_drain_exit;
    logic w_drain_tmo;
    logic w_tmo_err;
    logic w_last_point;

    assign w_ar_hs      = bus.axi_arvalid & bus.axi_arready;
    assign w_r_done     = bus.axi_rvalid & bus.axi_rready & bus.axi_rlast;
    assign w_uflow      = w_r_done & ~w_ar_hs & (r_outst == '0);
    assign w_oflow      = w_ar_hs & ~w_r_done & (&r_outst);
    assign w_err_evt    = (r_state != c_st_setup) & (w_uflow | w_oflow);
    assign w_drain_exit = ~bus.axi_arvalid & (r_outst == '0);
    assign w_drain_tmo  = (r_drain == c_drn_last);
    assign w_tmo_err    = (r_state == c_st_drain) & w_drain_tmo & ~w_drain_exit;
    assign w_last_point = (r_arsize == c_size_max) & (r_arlen == r_len_max);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (bus.start) w_state_nxt = c_st_setup;
            c_st_setup:  w_state_nxt = c_st_run;
            c_st_run:    if (r_win == c_win_last) w_state_nxt = c_st_drain;
            c_st_drain:  if (w_drain_exit || w_drain_tmo) w_state_nxt = c_st_report;
            c_st_report: if (bus.result_ready) w_state_nxt = w_last_point ? c_st_done : c_st_setup;
            c_st_done:   w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_len_max    <= '0;
            r_arsize     <= c_size_min;
            r_arlen      <= '0;
            r_win        <= '0;
            r_drain      <= '0;
            r_outst      <= '0;
            r_err        <= 1'b0;
            r_count      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pause      <= 1'b1;
            r_dbg_arsize <= c_size_min;
            r_dbg_arlen  <= '0;
            r_res_valid  <= 1'b0;
            r_res_arsize <= c_size_min;
            r_res_arlen  <= '0;
            r_res_count  <= '0;
            r_res_err    <= 1'b0;
        end else begin
            if (r_state == c_st_idle && bus.start) begin
                r_len_max <= bus.cfg_len_max;
                r_arsize  <= c_size_min;
                r_arlen   <= '0;
            end else if (r_state == c_st_report && bus.result_ready && !w_last_point) begin
                if (r_arlen == r_len_max) begin
                    r_arlen  <= '0;
                    r_arsize <= r_arsize + 3'd1;
                end else begin
                    r_arlen <= r_arlen + LEN_SIZE'(1);
                end
            end

            if (r_state == c_st_setup) begin
                r_win <= '0;
            end else if (r_state == c_st_run) begin
                r_win <= r_win + c_win_w'(1);
            end
            r_drain <= (r_state == c_st_drain) ? r_drain + c_drn_w'(1) : '0;

            // A timed-out drain leaves stale bursts in flight; the next point starts from zero.
            if (r_state == c_st_setup) begin
                r_outst <= '0;
            end else if (w_ar_hs && !w_r_done && !(&r_outst)) begin
                r_outst <= r_outst + OUTST_W'(1);
            end else if (w_r_done && !w_ar_hs && (r_outst != '0)) begin
                r_outst <= r_outst - OUTST_W'(1);
            end

            if (r_state == c_st_setup) begin
                r_err <= 1'b0;
            end else if (w_err_evt || w_tmo_err) begin
                r_err <= 1'b1;
            end

            if (r_state == c_st_setup) begin
                r_count <= '0;
            end else if (r_state == c_st_run && w_r_done && !(&r_count)) begin
                r_count <= r_count + 32'd1;
            end

            r_busy      <= (w_state_nxt != c_st_idle);
            r_done      <= (w_state_nxt == c_st_done);
            r_pause     <= (w_state_nxt != c_st_run);
            r_res_valid <= (w_state_nxt == c_st_report);

            if (r_state == c_st_setup) begin
                r_dbg_arsize <= r_arsize;
                r_dbg_arlen  <= r_arlen;
            end

            // Snapshot on REPORT entry so result fields hold still while unacknowledged.
            if (r_state != c_st_report && w_state_nxt == c_st_report) begin
                r_res_arsize <= r_arsize;
                r_res_arlen  <= r_arlen;
                r_res_count  <= r_count;
                r_res_err    <= r_err | w_err_evt | w_tmo_err;
            end
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.debug_pause   = r_pause;
    assign bus.debug_arsize  = r_dbg_arsize;
    assign bus.debug_arlen   = r_dbg_arlen;
    assign bus.result_valid  = r_res_valid;
    assign bus.result_arsize = r_res_arsize;
    assign bus.result_arlen  = r_res_arlen;
    assign bus.result_count  = r_res_count;
    assign bus.result_err    = r_res_err;
endmodule
`default_nettype wire

// File: tb/tb_iops_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_iops_sweep_ctrl
// Brief    : Scoreboard bench for iops_sweep_ctrl with a generator/slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iops_sweep_ctrl;
    localparam int LEN_SIZE      = 4;
    localparam int SIZE_MIN      = 2;
    localparam int SIZE_MAX      = 3;
    localparam int WINDOW_LEN    = 20;
    localparam int OUTST_W       = 8;
    localparam int DRAIN_TIMEOUT = 100;

    typedef struct {
        int     sz;
        int     ln;
        longint cnt;
        int     err;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    iops_sweep_ctrl_if #(.LEN_SIZE(LEN_SIZE)) bus ();

    iops_sweep_ctrl #(
        .LEN_SIZE     (LEN_SIZE),
        .SIZE_MIN     (SIZE_MIN),
        .SIZE_MAX     (SIZE_MAX),
        .WINDOW_LEN   (WINDOW_LEN),
        .OUTST_W      (OUTST_W),
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    exp_t sb[$];
    int results_seen = 0;

    // Bench-side model state
    logic        pause_prev = 1'b1;
    int          run_len = 0, cfg_bad = 0, tally = 0, done_cnt = 0;
    logic [6:0]  cfg_snap = '0;
    int          exp_size = SIZE_MIN, exp_len = 0, sweep_len_max = 0, exp_err = 0;
    int          hand_pts = 0, hand_err = 0;
    longint      hand_cnt = 0;
    logic        in_drain = 1'b0;
    int          drain_cnt = 0, check_drain_len = 0;
    int          hold_left = 0;
    logic        hold_active = 1'b0;
    logic [42:0] hold_snap = '0;
    logic        start_req = 1'b0, manual = 1'b0, arready_en = 1'b1;
    logic        man_ar = 1'b0, man_r = 1'b0;
    logic [2:0]  rpipe = '0;

    function automatic void check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // One bench cycle: observe what happened at the last edge, then drive the next cycle.
    task automatic tick();
        logic       ar_hs, r_dn;
        logic [6:0] cfg_now;
        logic [42:0] res_vec;
        exp_t       e;
        @(negedge clock);
        ar_hs = bus.axi_arvalid & bus.axi_arready;
        r_dn  = bus.axi_rvalid & bus.axi_rready & bus.axi_rlast;
        if (r_dn && !pause_prev) tally++;
        if (bus.done) done_cnt++;
        cfg_now = {bus.debug_arsize, bus.debug_arlen};
        if (pause_prev && !bus.debug_pause) begin
            run_len  = 1;
            cfg_snap = cfg_now;
            cfg_bad  = 0;
            check("run_arsize", bus.debug_arsize, exp_size);
            check("run_arlen", bus.debug_arlen, exp_len);
        end else if (!pause_prev && !bus.debug_pause) begin
            run_len++;
            if (cfg_now != cfg_snap) cfg_bad++;
        end else if (!pause_prev && bus.debug_pause) begin
            check("window_len", run_len, WINDOW_LEN);
            check("cfg_stable", cfg_bad, 0);
            e.sz  = exp_size;
            e.ln  = exp_len;
            e.cnt = (hand_pts > 0) ? hand_cnt : longint'(tally);
            e.err = (hand_pts > 0) ? hand_err : exp_err;
            if (hand_pts > 0) hand_pts--;
            sb.push_back(e);
            tally = 0;
            if (exp_len == sweep_len_max) begin
                exp_len = 0;
                exp_size++;
            end else begin
                exp_len++;
            end
            in_drain  = 1'b1;
            drain_cnt = 1;
        end else if (in_drain) begin
            if (bus.result_valid) begin
                in_drain = 1'b0;
                if (check_drain_len > 0) check("drain_len", drain_cnt, check_drain_len);
            end else begin
                drain_cnt++;
            end
        end
        pause_prev = bus.debug_pause;

        res_vec = {bus.result_valid, bus.debug_pause, bus.busy, bus.result_arsize,
                   bus.result_arlen, bus.result_count, bus.result_err};
        if (hold_left > 0 && (hold_active || bus.result_valid)) begin
            if (!hold_active) begin
                hold_active = 1'b1;
                hold_snap   = res_vec;
                check("hold_pause", bus.debug_pause, 1);
            end else begin
                check("hold_stable", longint'(res_vec), longint'(hold_snap));
            end
            hold_left--;
            bus.result_ready = 1'b0;
        end else begin
            hold_active      = 1'b0;
            bus.result_ready = 1'b1;
        end

        if (manual) begin
            bus.axi_arvalid = man_ar;
            bus.axi_arready = man_ar;
            bus.axi_rvalid  = man_r;
            bus.axi_rready  = man_r;
            bus.axi_rlast   = man_r;
            rpipe = '0;
        end else begin
            if (!(bus.axi_arvalid && !ar_hs)) bus.axi_arvalid = ~bus.debug_pause;
            bus.axi_arready = arready_en;
            rpipe = {rpipe[1:0], ar_hs};
            bus.axi_rvalid = rpipe[2];
            bus.axi_rlast  = rpipe[2];
            bus.axi_rready = 1'b1;
        end
        bus.start = start_req;
        start_req = 1'b0;
    endtask

    task automatic start_sweep(input int len_max);
        sweep_len_max   = len_max;
        exp_size        = SIZE_MIN;
        exp_len         = 0;
        done_cnt        = 0;
        tally           = 0;
        bus.cfg_len_max = LEN_SIZE'(len_max);
        start_req       = 1'b1;
        tick();
        tick();
        check("busy_after_start", bus.busy, 1);
        bus.cfg_len_max = LEN_SIZE'(len_max + 2);
    endtask

    task automatic finish_sweep(input int n_results, input int seen0);
        int cyc = 0;
        while (!(done_cnt > 0 && bus.busy == 1'b0) && cyc < 3000) begin
            tick();
            cyc++;
            if (cyc == 25) start_req = 1'b1;
        end
        check("sweep_timeout", longint'(cyc >= 3000), 0);
        repeat (3) tick();
        check("done_pulses", done_cnt, 1);
        check("busy_idle", bus.busy, 0);
        check("result_total", results_seen - seen0, n_results);
        check("sb_left", sb.size(), 0);
    endtask

    task automatic man_tick(input logic ar, input logic r);
        man_ar = ar;
        man_r  = r;
        tick();
    endtask

    // Scoreboard monitor: compares every accepted result against the queue head.
    always begin
        exp_t e;
        @(negedge clock);
        #2;
        if (bus.result_valid === 1'b1 && bus.result_ready === 1'b1) begin
            results_seen++;
            if (sb.size() == 0) begin
                check("sb_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("res_arsize", bus.result_arsize, e.sz);
                check("res_arlen", bus.result_arlen, e.ln);
                check("res_count", bus.result_count, e.cnt);
                check("res_err", bus.result_err, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen0;
        int cyc;
        bus.start = 1'b0;
        bus.cfg_len_max = '0;
        bus.axi_arvalid = 1'b0;
        bus.axi_arready = 1'b0;
        bus.axi_rvalid = 1'b0;
        bus.axi_rready = 1'b0;
        bus.axi_rlast = 1'b0;
        bus.result_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_pause", bus.debug_pause, 1);
        check("rst_arsize", bus.debug_arsize, SIZE_MIN);
        check("rst_arlen", bus.debug_arlen, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rvalid", bus.result_valid, 0);
        check("rst_rcount", bus.result_count, 0);
        check("rst_rerr", bus.result_err, 0);
        reset = 1'b0;
        repeat (2) tick();

        // Full sweep, 3-cycle read latency, first result held off for 50 cycles
        manual = 1'b0; arready_en = 1'b1; exp_err = 0;
        hand_pts = 4; hand_cnt = WINDOW_LEN - 3; hand_err = 0;
        hold_left = 50;
        seen0 = results_seen;
        start_sweep(1);
        finish_sweep(4, seen0);

        // Slave never accepts AR: every point times out in DRAIN
        arready_en = 1'b0; exp_err = 1; check_drain_len = DRAIN_TIMEOUT;
        hand_pts = 2; hand_cnt = 0; hand_err = 1;
        seen0 = results_seen;
        start_sweep(0);
        finish_sweep(2, seen0);
        check_drain_len = 0;
        arready_en = 1'b1;

        // Hand-driven AR/R traffic: same-cycle events and a spurious rlast
        manual = 1'b1; man_ar = 1'b0; man_r = 1'b0; exp_err = 0;
        hand_pts = 1; hand_cnt = 4; hand_err = 1;
        seen0 = results_seen;
        start_sweep(0);
        cyc = 0;
        while (bus.debug_pause && cyc < 20) begin
            tick();
            cyc++;
        end
        check("run_entry_timeout", longint'(cyc >= 20), 0);
        man_tick(1'b1, 1'b0);
        man_tick(1'b1, 1'b0);
        man_tick(1'b1, 1'b1);
        check("outst_two", dut.r_outst, 2);
        man_tick(1'b0, 1'b1);
        check("outst_same_cycle", dut.r_outst, 2);
        man_tick(1'b0, 1'b1);
        man_tick(1'b0, 1'b1);
        man_tick(1'b0, 1'b0);
        check("outst_underflow_hold", dut.r_outst, 0);
        finish_sweep(2, seen0);

        // Asynchronous reset in the middle of RUN
        manual = 1'b0; hand_pts = 0;
        start_sweep(0);
        cyc = 0;
        while (bus.debug_pause && cyc < 20) begin
            tick();
            cyc++;
        end
        repeat (5) tick();
        check("pre_reset_pause", bus.debug_pause, 0);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_pause", bus.debug_pause, 1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_rvalid", bus.result_valid, 0);
        sb.delete();
        pause_prev = 1'b1; run_len = 0; tally = 0; in_drain = 1'b0; rpipe = '0;
        bus.axi_arvalid = 1'b0; bus.axi_rvalid = 1'b0; bus.axi_rlast = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        seen0 = results_seen;
        start_sweep(0);
        finish_sweep(2, seen0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/iops_sweep_ctrl.md
Name: iops_sweep_ctrl

Overview:
- Sequencer for the random-read IOPS generator. Drives the generator's debug_arsize, debug_arlen and debug_pause inputs.
- Steps through a configuration sweep. Each point gets a fixed-length measurement window, after which the controller drains all in-flight reads.
- Per point, reports the number of completed read bursts on a valid/ready result interface. Sits beside the generator and snoops its AXI AR/R channels.

Parameters:
- LEN_SIZE, 4, width of arlen (4 = AXI3, 8 = AXI4).
- SIZE_MIN, 0, first arsize in the sweep.
- SIZE_MAX, 3, last arsize in the sweep; must be <= log2(DATA_LEN/8).
- WINDOW_LEN, 1024, RUN-state length in cycles; must be >= 1.
- OUTST_W, 8, width of the outstanding-burst counter.
- DRAIN_TIMEOUT, 65535, maximum DRAIN cycles before an error is flagged.

Ports:
- clock  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a sweep; ignored while busy.
- cfg_len_max  in  LEN_SIZE  last arlen in the sweep; sampled on start.
- busy  out  1  high from the cycle after an accepted start until DONE completes.
- done  out  1  one-cycle pulse at the end of a sweep.
- debug_arsize  out  3  to generator.
- debug_arlen  out  LEN_SIZE  to generator.
- debug_pause  out  1  to generator; 1 = stop issuing.
- axi_arvalid  in  1  snooped AR valid.
- axi_arready  in  1  snooped AR ready.
- axi_rvalid  in  1  snooped R valid.
- axi_rready  in  1  snooped R ready.
- axi_rlast  in  1  snooped R last.
- result_valid  out  1  result available.
- result_ready  in  1  result consumed.
- result_arsize  out  3  arsize of the reported point.
- result_arlen  out  LEN_SIZE  arlen of the reported point.
- result_count  out  32  completed bursts during RUN.
- result_err  out  1  drain timeout or outstanding underflow occurred at this point.

Behaviour:
- Reset is asynchronous. All outputs are registered.
- Reset values:
  - debug_pause=1; debug_arsize=SIZE_MIN; debug_arlen=0.
  - busy=0; done=0; result_valid=0; result_count=0; result_err=0.
  - FSM=IDLE; all counters 0.
- Events:
  - AR handshake: axi_arvalid & axi_arready.
  - R completion: axi_rvalid & axi_rready & axi_rlast.
- Outstanding counter:
  - +1 per AR handshake, -1 per R completion; same-cycle AR and R leaves it unchanged.
  - Decrement at 0 holds 0 and sets the point error flag.
  - Increment at all-ones saturates and sets the error flag.
- FSM:
  - IDLE: debug_pause=1. On start, latch cfg_len_max, set arsize=SIZE_MIN and arlen=0, then go to SETUP.
  - SETUP (1 cycle):
    - Drive debug_arsize/debug_arlen from the point registers.
    - Clear the window counter, completion count and error flag.
    - Go to RUN; debug_pause falls on entry to RUN.
  - RUN:
    - debug_pause=0 for exactly WINDOW_LEN cycles.
    - Count R completions during these cycles, saturating at 32'hFFFFFFFF.
    - Config outputs are stable throughout.
    - After the WINDOW_LEN-th cycle, go to DRAIN; debug_pause=1 from the first DRAIN cycle.
  - DRAIN:
    - Wait until !axi_arvalid and outstanding==0, sampled in the same cycle, then go to REPORT.
    - Completions in DRAIN are not counted but do decrement outstanding.
    - If DRAIN_TIMEOUT cycles elapse, set the error flag and go to REPORT. Outstanding is not cleared; it is forced to 0 in SETUP of the next point.
  - REPORT:
    - result_valid=1 with result_* stable until result_ready.
    - On the handshake cycle, advance the point and go to SETUP, or to DONE after the last point.
    - Advance order: arlen increments first. When arlen==latched max, arlen returns to 0 and arsize increments.
    - Last point: arsize==SIZE_MAX and arlen==max.
  - DONE: done=1 for one cycle, busy falls, then IDLE.
- Sweep size: (SIZE_MAX-SIZE_MIN+1)*(max+1) results.
- result_ready while result_valid=0 is ignored.
- start while busy is ignored.
- cfg_len_max changes during a sweep have no effect.
- Reset mid-sweep: immediate return to IDLE with debug_pause=1; a partial result is discarded.

Test Plan:
1. Slave with arready=1 and one-beat R 3 cycles after AR; SIZE_MIN=2, SIZE_MAX=3, cfg_len_max=1; start. Required: 4 results in order (2,0),(2,1),(3,0),(3,1). Each result_count equals the bench's R-completion tally over the WINDOW_LEN unpaused cycles. result_err=0, then a single done pulse.
2. debug_pause check: high at all times except exactly WINDOW_LEN consecutive cycles per point. Config outputs do not change while pause=0.
3. Slave with arready tied 0; DRAIN_TIMEOUT=100. Required: result_count=0, result_err=1 after 100 DRAIN cycles, and the sweep continues.
4. result_ready held 0 for 50 cycles in REPORT. Required: result_valid and fields stable, no SETUP entered, debug_pause=1 throughout.
5. AR handshake and R completion in the same cycle with outstanding=2. Required: outstanding stays 2. Spurious rlast at outstanding=0 gives result_err=1.
6. Reset asserted mid-RUN. Required: debug_pause=1 immediately (asynchronous), busy=0, result_valid=0. Next start begins at (SIZE_MIN,0).
